hazard_unit: RTL

Parametrised hazard and forwarding controller for the pipelined CPU. It tracks destination-register and flag-writer records for the DEPTH stages after ID and selects operand forwarding sources for Rn/Rm. It raises a stall on load-use, flag, and memory-busy hazards, and flushes IF/ID on a taken branch resolved in ID. It sits beside control, taking decoded ID-stage fields and driving the PC/IF-ID freeze and datapath forwarding muxes.

---
 rtl/hazard_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: hazard detection and operand-forwarding controller.
// It keeps a record for each of the DEPTH stages after ID (1 = EX, 2 = MEM,
// 3 = WB, ...). From these records it picks the forwarding source for Rn and Rm.
// It stalls on load-use, flag and memory-busy hazards.
// It flushes IF/ID on a taken branch that is resolved in ID.
// Optional feature macro: FLAG_FWD_EN.
//   - Defined: flag forwarding is used (fwd_flag port) and flag dependences never stall.
//   - Undefined: a B.cond waits until no flag setter is left in stages 1..2.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_rn_used,
    input  logic                  id_rm_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_set_flag,
    input  logic                  id_flag_use,
    input  logic                  br_taken,
    input  logic                  mem_busy,
    output logic                  stall,
    output logic                  if_id_flush,
    output logic [FW-1:0]         fwd_a,
    output logic [FW-1:0]         fwd_b,
`ifdef FLAG_FWD_EN
    output logic [FW-1:0]         fwd_flag,
`endif
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    // Per-stage records; index k is stage k after ID.
    logic [DEPTH:1]        valid_reg;
    logic [DEPTH:1]        rw_reg;
    logic [DEPTH:1]        m2r_reg;
    logic [DEPTH:1]        sf_reg;
    logic [REG_ADDR_W-1:0] rd_reg [1:DEPTH];
    logic [CNT_W-1:0]      stall_cnt_reg;

    logic [DEPTH:1] hit_a;
    logic [DEPTH:1] hit_b;
    logic           load_use;
    logic           flag_stall;
    logic           stall_next;

    // A stage matches a source when it writes the same register.
    // Writes to XZR never match, and neither does a source that is not read.
    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_match
            assign hit_a[gi] = valid_reg[gi] & rw_reg[gi] & id_rn_used &
                               (rd_reg[gi] == id_rn) & (rd_reg[gi] != ZERO_ADDR);
            assign hit_b[gi] = valid_reg[gi] & rw_reg[gi] & id_rm_used &
                               (rd_reg[gi] == id_rm) & (rd_reg[gi] != ZERO_ADDR);
        end
    endgenerate

    // Forwarding priority: scan from the oldest stage to the youngest, so the youngest match wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit_a[k]) fwd_a = FW'(k);
            if (hit_b[k]) fwd_b = FW'(k);
        end
    end

`ifdef FLAG_FWD_EN
    // Flag source: the youngest in-flight flag setter, used only when ID consumes the flags.
    always_comb begin
        fwd_flag = '0;
        if (id_flag_use) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (valid_reg[k] && sf_reg[k]) fwd_flag = FW'(k);
            end
        end
    end
    assign flag_stall = 1'b0;
`else
    // The flag register is read directly, so ID waits until setters have left EX and MEM.
    assign flag_stall = id_valid & id_flag_use &
                        ((valid_reg[1] & sf_reg[1]) | (valid_reg[2] & sf_reg[2]));
`endif

    // A load result is not available from EX.
    // Only a real ID instruction can be blocked by a load in EX.
    assign load_use   = id_valid & m2r_reg[1] & (hit_a[1] | hit_b[1]);

    // While reset is held, all outputs read as idle.
    assign stall_next  = load_use | flag_stall | mem_busy;
    assign stall       = reset & stall_next;
    assign if_id_flush = reset & br_taken & id_valid & ~stall_next;
    assign stall_cnt   = stall_cnt_reg;

    // Record pipeline: memory busy freezes every record.
    // Otherwise records shift, and stage 1 takes the ID record or a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
            rw_reg    <= '0;
            m2r_reg   <= '0;
            sf_reg    <= '0;
            for (int k = 1; k <= DEPTH; k++) rd_reg[k] <= '0;
        end else if (!mem_busy) begin
            for (int k = DEPTH; k >= 2; k--) begin
                valid_reg[k] <= valid_reg[k-1];
                rw_reg[k]    <= rw_reg[k-1];
                m2r_reg[k]   <= m2r_reg[k-1];
                sf_reg[k]    <= sf_reg[k-1];
                rd_reg[k]    <= rd_reg[k-1];
            end
            valid_reg[1] <= id_valid & ~stall_next;
            rw_reg[1]    <= id_reg_write;
            m2r_reg[1]   <= id_mem_to_reg;
            sf_reg[1]    <= id_set_flag;
            rd_reg[1]    <= id_rd;
        end
    end

    // Stall-cycle counter: it sticks at all-ones and does not wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (stall_next && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule
